ram_dma: RTL
============

// Module: ram_dma
// PURPOSE
//   Upstream sequencer for the 4K x 16 RAM (sync write, 1-cycle registered read). On start:
//   - FILL: streams words from a valid/ready source into consecutive RAM addresses.
//   - DUMP: reads consecutive addresses out to a valid/ready sink, absorbing the read latency.
//   Used for program/data loading and memory dumps in bench and system bring-up.
// PARAMETERS
//   DATA_W   16   RAM word width
//   ADDR_W   12   RAM address width (depth 2**ADDR_W = 4096)
// PORTS
//   clk          in   1       single clock, rising edge
//   reset        in   1       asynchronous, active-high
//   start        in   1       begin transfer; sampled only in IDLE
//   mode         in   1       0 = FILL, 1 = DUMP; sampled with start
//   base_addr    in   ADDR_W  first RAM address; sampled with start
//   count        in   ADDR_W+1 words to move, 0..4096; values >4096 clamp to 4096
//   busy         out  1       high whenever state != IDLE
//   done         out  1       one-cycle pulse at end of transfer
//   s_data       in   DATA_W  FILL source word
//   s_valid      in   1       source word valid
//   s_ready      out  1       = (state==FILL)
//   m_data       out  DATA_W  DUMP sink word
//   m_valid      out  1       sink word valid
//   m_ready      in   1       sink accepts
//   ram_in       out  DATA_W  to RAM data input
//   ram_address  out  ADDR_W  to RAM address
//   ram_load     out  1       to RAM write enable
//   ram_out      in   DATA_W  from RAM; holds ram[address presented on previous edge]
// BEHAVIOUR
//   Reset (async): state=IDLE; busy, done, m_valid, ram_load = 0; counters and skid buffer cleared.
//   Reset mid-transfer aborts it; no done pulse.
//   FSM: IDLE -> FILL | DUMP (on start & count!=0); IDLE -> DONE (start & count==0, no RAM access);
//     FILL -> DONE after last handshake; DUMP -> DRAIN after last read issued;
//     DRAIN -> DONE when skid buffer empty and no read in flight; DONE -> IDLE (done=1 here only).
//   start while busy: ignored.
//   Addressing: addr = (base_addr + index) mod 4096; wraps 4095 -> 0.
//   FILL: ram_load = s_valid & s_ready (combinational), ram_in = s_data, ram_address = base+wr_idx.
//     wr_idx increments per handshake. Zero added latency; s_valid gaps are allowed.
//   DUMP: ram_load = 0 always.
//     Read issued when (buffer entries + in-flight reads) < 2 and rd_idx < count.
//     ram_address = base+rd_idx on issue; data captured from ram_out one cycle later into the
//     2-entry skid buffer.
//     m_valid = buffer non-empty; m_data = buffer head; pop on m_valid & m_ready.
//     Words are emitted in address order; none lost or duplicated under any m_ready pattern.
//     With m_ready held high: first m_valid 2 cycles after start; then 1 word/cycle.
//   ram_address holds its last value in IDLE/DONE; ram_load is 0 outside FILL.
// CONFIGURATION
//   RAM_DMA_CHECKSUM_EN defined:
//     - adds output checksum[DATA_W-1:0]: mod-2^16 sum of every word moved (FILL handshakes /
//       DUMP pops).
//     - cleared on accepted start; final value valid from the done pulse until next start.
//     - reset value 0.
//   Undefined: no checksum port or logic.
// STRUCTURE
//   Package ram_dma_pkg: DATA_W/ADDR_W defaults, MODE_FILL/MODE_DUMP constants,
//     state enum {IDLE, FILL, DUMP, DRAIN, DONE}.
//   Sub-module ram_dma_skid: 2-entry FIFO with push/pop/count, async reset.
// TESTING
//   1. FILL base=0, count=4, s_valid=1, data 1,2,3,4 -> ram[0..3]=1..4; done 1 cycle after last
//      handshake; busy low after.
//   2. FILL base=4094, count=4 -> writes at 4094,4095,0,1 (wrap).
//   3. DUMP base=0, count=4 after test 1, m_ready=1 -> m_data 1,2,3,4 on consecutive cycles,
//      first valid 2 cycles after start.
//   4. DUMP count=8, m_ready toggling randomly / held low 5 cycles -> exact in-order sequence,
//      m_data stable while m_valid & !m_ready.
//   5. start with count=0 -> done pulse next cycle, ram_load never asserted; start during busy
//      ignored.
//   6. reset asserted mid-FILL -> ram_load drops immediately, no done.
//      With RAM_DMA_CHECKSUM_EN: test 1 gives checksum=10.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// Shared constants and types for the RAM fill/dump sequencer.
package ram_dma_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 12;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_DUMP = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DUMP,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/ram_dma_skid.sv
// Two-entry FIFO that absorbs the RAM read latency on the dump path.
// The head entry is always held in d0_q, so the output is a plain register.
module ram_dma_skid
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] d0_q, d0_d;
  logic [W-1:0] d1_q, d1_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next-state for the two slots; pop shifts slot 1 into the head.
  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          d0_d = din_i;
        end else begin
          d1_d = din_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = din_i;
        end else begin
          d0_d = d1_q;
          d1_d = din_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_q  <= '0;
      d1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = d0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ram_dma.sv
// Fill/dump sequencer in front of a sync-write, 1-cycle-read RAM.
// FILL streams a valid/ready source into consecutive addresses; DUMP reads
// consecutive addresses out to a valid/ready sink through a 2-entry skid.
// Optional macro RAM_DMA_CHECKSUM_EN adds a running 16-bit sum of moved words.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
`ifdef RAM_DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              pend_q, pend_d;

  logic [CNT_W-1:0]  count_clamp_c;
  logic              start_acc_c;
  logic              fill_hs_c;
  logic              pop_c;
  logic              issue_c;
  logic              last_c;
  logic [2:0]        occ_c;
  logic [1:0]        skid_cnt;

  // Dump-path buffer: captures ram_out the cycle after a read is issued.
  ram_dma_skid #(
    .W(DATA_W)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .push_i (pend_q),
    .din_i  (ram_out),
    .pop_i  (pop_c),
    .head_o (m_data),
    .count_o(skid_cnt)
  );

  // Handshakes, read-issue credit and port decode.
  always_comb begin
    count_clamp_c = (count > MAX_CNT) ? MAX_CNT : count;
    start_acc_c   = (state_q == IDLE) && start;
    s_ready       = (state_q == FILL);
    fill_hs_c     = s_valid && s_ready;
    ram_load      = fill_hs_c;
    ram_in        = s_data;
    ram_address   = addr_q;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    m_valid       = (skid_cnt != 2'd0);
    pop_c         = m_valid && m_ready;
    // A pop this cycle frees a slot in time for the read issued now.
    occ_c         = 3'(skid_cnt) + 3'(pend_q) - 3'(pop_c);
    last_c        = (idx_q == (count_q - CNT_W'(1)));
    issue_c       = (state_q == DUMP) && (occ_c < 3'd2) && (idx_q < count_q);
  end

  // Next-state logic for the transfer FSM and its address/index counters.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    idx_d   = idx_q;
    pend_d  = issue_c;
    unique case (state_q)
      IDLE: begin
        if (start_acc_c) begin
          count_d = count_clamp_c;
          addr_d  = base_addr;
          idx_d   = '0;
          if (count_clamp_c == '0) begin
            state_d = DONE;
          end else if (mode == MODE_DUMP) begin
            state_d = DUMP;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (fill_hs_c) begin
          addr_d = addr_q + ADDR_W'(1);
          idx_d  = idx_q + CNT_W'(1);
          if (last_c) begin
            state_d = DONE;
          end
        end
      end
      DUMP: begin
        if (issue_c) begin
          addr_d = addr_q + ADDR_W'(1);
          idx_d  = idx_q + CNT_W'(1);
          if (last_c) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((skid_cnt == 2'd0) && !pend_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

`ifdef RAM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Running sum of words moved; cleared when a transfer is accepted.
  always_comb begin
    csum_d = csum_q;
    if (start_acc_c) begin
      csum_d = '0;
    end else if (fill_hs_c) begin
      csum_d = csum_q + s_data;
    end else if (pop_c) begin
      csum_d = csum_q + m_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule
